csr_llbit_unit: RTL and testbench
=================================

Name: csr_llbit_unit

Overview:
- Backend responder for the CSR and LL/SC traffic produced by the 2RI14 decoder.
- Holds the core CSR file and executes CSRRD, CSRWR and CSRXCHG on commit.
- Maintains the LLbit and LLBCTL state for LL.W and SC.W.
- Runs exception entry and ERTN, the constant timer, and generates the interrupt-pending signal for the commit stage.

Parameters:
- TID_INIT, 32'h0, reset value of the TID register.
- TIMER_W, 32, width of the TCFG.InitVal+2 and TVAL counter. Must be 8 to 32.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- csr_read_en  in  1  read request (read is combinational)
- csr_read_addr  in  14  CSR number
- csr_read_data  out  32  read data; 0 when not enabled or the address is unimplemented
- csr_write_en  in  1  commit-stage write
- csr_write_addr  in  14  CSR number
- csr_write_data  in  32  write data
- csr_write_mask  in  32  bit mask: all-ones for CSRWR, rj value for CSRXCHG
- llbit_set  in  1  LL.W committed
- sc_commit  in  1  SC.W committed
- llbit  out  1  current LLbit (the SC.W success value)
- exc_valid  in  1  exception commit
- exc_ecode  in  6  Ecode
- exc_esubcode  in  9  EsubCode
- exc_pc  in  32  faulting PC
- ertn  in  1  ERTN committed
- hwi  in  8  hardware interrupt lines
- exc_entry_pc  out  32  equals EENTRY
- ertn_pc  out  32  equals ERA
- int_pending  out  1  CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0])

Behaviour:

Implemented CSRs (address: writable bits):
- CRMD 0x00: [8:0]
- PRMD 0x01: [2:0]
- ECFG 0x04: LIE [12:0]
- ESTAT 0x05: only IS[1:0] writable; IS[9:2] mirror hwi, registered each cycle; IS[11] is the timer interrupt; Ecode at [21:16]; EsubCode at [30:22]
- ERA 0x06: all bits
- EENTRY 0x0C: [31:6]; [5:0] read 0
- SAVE0..3 0x30..0x33: all bits
- TID 0x40: all bits
- TCFG 0x41: [TIMER_W-1:0]; En is bit0, Periodic is bit1, InitVal is [TIMER_W-1:2]
- TVAL 0x42: read-only
- TICLR 0x44: write-only; reads 0
- LLBCTL 0x60: ROLLB bit0 reads llbit; WCLLB bit1 is write-1-to-clear of llbit and reads 0; KLO bit2 is writable

General rules:
- Reset (async) values: CRMD = 32'h8 (DA=1, PLV=0, IE=0); TID = TID_INIT; all other CSRs, llbit and outputs derived from them = 0.
- Writes:
  - Take effect at the next posedge.
  - new = (old & ~mask) | (data & mask), restricted to the writable bits.
  - Writes to an unimplemented or read-only address are ignored.
- Reads return register contents with no bypass from a same-cycle write; hazards are owned by the pipeline.

Priority within one cycle: exc_valid > ertn > csr_write_en.
- A CSR write is dropped if exc_valid or ertn is asserted in the same cycle.
- exc_valid and ertn together: the exception wins.

Exception entry:
- PRMD.PPLV ← CRMD.PLV; PRMD.PIE ← CRMD.IE.
- CRMD.PLV ← 0; CRMD.IE ← 0.
- ERA ← exc_pc.
- ESTAT.Ecode ← exc_ecode; ESTAT.EsubCode ← exc_esubcode.

ERTN:
- CRMD.PLV ← PRMD.PPLV; CRMD.IE ← PRMD.PIE.
- If LLBCTL.KLO = 0, llbit ← 0. KLO ← 0 in either case.

LLbit update (applied after the ERTN and LLBCTL effects):
- llbit_set sets llbit to 1.
- sc_commit clears it.
- Both asserted: set wins.
- A WCLLB write in the same cycle as llbit_set: set wins.

Timer:
- A TCFG write with En=1 loads TVAL ← {InitVal, 2'b00}.
- While En=1 and TVAL≠0, TVAL decrements by 1 each cycle.
- When En=1 and TVAL=0:
  - ESTAT.IS[11] is set.
  - If Periodic=1, TVAL is reloaded; otherwise TCFG.En ← 0, so the timer fires only once.
- A TICLR write with bit0=1 clears IS[11]. A fire in the same cycle wins over the clear.
- The TVAL reload from a TCFG write overrides the decrement.

Other:
- int_pending is combinational from registered state.
- A reset in mid-operation aborts everything to the reset values, including the counter.

Test Plan:
- Reset, then read CRMD → 32'h8; read TID → TID_INIT; read unimplemented 0x7F → 0.
- CSRXCHG to SAVE0 (old 32'hFFFF0000, data 32'h1234ABCD, mask 32'h0000FFFF) → SAVE0 = 32'hFFFFABCD next cycle; a same-cycle read returns 32'hFFFF0000.
- Sequence: CRMD.PLV=3, IE=1; exc_valid with ecode 6'h0B and pc 32'h1C000100; a CSR write in the same cycle → PRMD=3'b111, CRMD PLV=0 IE=0, ERA=32'h1C000100, Ecode=0x0B, write dropped. Then ertn → PLV=3, IE=1.
- Sequence: llbit_set → llbit=1; ertn with KLO=1 → llbit stays 1 and KLO becomes 0; second ertn → llbit=0; llbit_set and sc_commit in the same cycle → llbit=1.
- Write TCFG = {InitVal=2, Periodic=1, En=1} → TVAL counts 8..0, IS[11] is set, TVAL reloads to 8; with ECFG.LIE[11]=1 and IE=1, int_pending=1; TICLR write → IS[11]=0 and int_pending=0.
- Non-periodic TCFG with InitVal=1 → fires once at TVAL=0, En clears, and IS[11] stays set with no second fire.

Source files
------------

// File: rtl/csr_llbit_unit.sv
// Core CSR file with LLbit/LLBCTL state, exception entry / ERTN, constant timer
// and interrupt-pending generation for the commit stage.
module csr_llbit_unit #(
    parameter logic [31:0] TID_INIT = 32'h0,
    parameter int          TIMER_W  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_read_en,
    input  logic [13:0] csr_read_addr,
    output logic [31:0] csr_read_data,
    input  logic        csr_write_en,
    input  logic [13:0] csr_write_addr,
    input  logic [31:0] csr_write_data,
    input  logic [31:0] csr_write_mask,
    input  logic        llbit_set,
    input  logic        sc_commit,
    output logic        llbit,
    input  logic        exc_valid,
    input  logic [5:0]  exc_ecode,
    input  logic [8:0]  exc_esubcode,
    input  logic [31:0] exc_pc,
    input  logic        ertn,
    input  logic [7:0]  hwi,
    output logic [31:0] exc_entry_pc,
    output logic [31:0] ertn_pc,
    output logic        int_pending
);

    localparam logic [13:0] A_CRMD   = 14'h000;
    localparam logic [13:0] A_PRMD   = 14'h001;
    localparam logic [13:0] A_ECFG   = 14'h004;
    localparam logic [13:0] A_ESTAT  = 14'h005;
    localparam logic [13:0] A_ERA    = 14'h006;
    localparam logic [13:0] A_EENTRY = 14'h00C;
    localparam logic [13:0] A_SAVE0  = 14'h030;
    localparam logic [13:0] A_SAVE1  = 14'h031;
    localparam logic [13:0] A_SAVE2  = 14'h032;
    localparam logic [13:0] A_SAVE3  = 14'h033;
    localparam logic [13:0] A_TID    = 14'h040;
    localparam logic [13:0] A_TCFG   = 14'h041;
    localparam logic [13:0] A_TVAL   = 14'h042;
    localparam logic [13:0] A_TICLR  = 14'h044;
    localparam logic [13:0] A_LLBCTL = 14'h060;

    function automatic logic [31:0] merge_f(input logic [31:0] old_v,
                                            input logic [31:0] data_v,
                                            input logic [31:0] mask_v);
        return (old_v & ~mask_v) | (data_v & mask_v);
    endfunction

    logic [8:0]         crmd_q, crmd_d;
    logic [2:0]         prmd_q, prmd_d;
    logic [12:0]        ecfg_q, ecfg_d;
    logic [1:0]         is_sw_q, is_sw_d;
    logic [7:0]         is_hw_q;
    logic               is_timer_q, is_timer_d;
    logic [5:0]         ecode_q, ecode_d;
    logic [8:0]         esubcode_q, esubcode_d;
    logic [31:0]        era_q, era_d;
    logic [25:0]        eentry_q, eentry_d;
    logic [31:0]        save0_q, save0_d, save1_q, save1_d;
    logic [31:0]        save2_q, save2_d, save3_q, save3_d;
    logic [31:0]        tid_q, tid_d;
    logic [TIMER_W-1:0] tcfg_q, tcfg_d;
    logic [TIMER_W-1:0] tval_q, tval_d;
    logic               klo_q, klo_d;
    logic               llbit_q, llbit_d;

    logic [31:0]        estat_s;
    logic [31:0]        tcfg_ext_s;
    logic [31:0]        tval_ext_s;
    logic [31:0]        wv_s;
    logic [TIMER_W-1:0] tcfg_new_s;
    logic               tcfg_wr_s;
    logic               ticlr_s;
    logic               wcllb_s;
    logic               ertn_clr_s;
    logic               fire_s;

    // Assemble the multi-field and parameter-width CSR views.
    always_comb begin
        estat_s = {1'b0, esubcode_q, ecode_q, 3'b000, 1'b0, is_timer_q, 1'b0, is_hw_q, is_sw_q};
        tcfg_ext_s = 32'h0;
        tcfg_ext_s[TIMER_W-1:0] = tcfg_q;
        tval_ext_s = 32'h0;
        tval_ext_s[TIMER_W-1:0] = tval_q;
    end

    // Combinational read port; no bypass from a same-cycle write.
    always_comb begin
        csr_read_data = 32'h0;
        if (csr_read_en) begin
            case (csr_read_addr)
                A_CRMD:   csr_read_data = {23'h0, crmd_q};
                A_PRMD:   csr_read_data = {29'h0, prmd_q};
                A_ECFG:   csr_read_data = {19'h0, ecfg_q};
                A_ESTAT:  csr_read_data = estat_s;
                A_ERA:    csr_read_data = era_q;
                A_EENTRY: csr_read_data = {eentry_q, 6'h00};
                A_SAVE0:  csr_read_data = save0_q;
                A_SAVE1:  csr_read_data = save1_q;
                A_SAVE2:  csr_read_data = save2_q;
                A_SAVE3:  csr_read_data = save3_q;
                A_TID:    csr_read_data = tid_q;
                A_TCFG:   csr_read_data = tcfg_ext_s;
                A_TVAL:   csr_read_data = tval_ext_s;
                A_LLBCTL: csr_read_data = {29'h0, klo_q, 1'b0, llbit_q};
                default:  csr_read_data = 32'h0;
            endcase
        end else begin
            csr_read_data = 32'h0;
        end
    end

    // Next-state: exception > ERTN > CSR write, then timer and LLbit updates.
    always_comb begin
        crmd_d     = crmd_q;
        prmd_d     = prmd_q;
        ecfg_d     = ecfg_q;
        is_sw_d    = is_sw_q;
        is_timer_d = is_timer_q;
        ecode_d    = ecode_q;
        esubcode_d = esubcode_q;
        era_d      = era_q;
        eentry_d   = eentry_q;
        save0_d    = save0_q;
        save1_d    = save1_q;
        save2_d    = save2_q;
        save3_d    = save3_q;
        tid_d      = tid_q;
        tcfg_d     = tcfg_q;
        tval_d     = tval_q;
        klo_d      = klo_q;
        llbit_d    = llbit_q;
        wv_s       = 32'h0;
        tcfg_new_s = tcfg_q;
        tcfg_wr_s  = 1'b0;
        ticlr_s    = 1'b0;
        wcllb_s    = 1'b0;
        ertn_clr_s = 1'b0;

        if (exc_valid) begin
            prmd_d      = {crmd_q[2], crmd_q[1:0]};
            crmd_d[2:0] = 3'b000;
            era_d       = exc_pc;
            ecode_d     = exc_ecode;
            esubcode_d  = exc_esubcode;
        end else if (ertn) begin
            crmd_d[2:0] = prmd_q;
            ertn_clr_s  = ~klo_q;
            klo_d       = 1'b0;
        end else if (csr_write_en) begin
            case (csr_write_addr)
                A_CRMD: begin
                    wv_s   = merge_f({23'h0, crmd_q}, csr_write_data, csr_write_mask);
                    crmd_d = wv_s[8:0];
                end
                A_PRMD: begin
                    wv_s   = merge_f({29'h0, prmd_q}, csr_write_data, csr_write_mask);
                    prmd_d = wv_s[2:0];
                end
                A_ECFG: begin
                    wv_s   = merge_f({19'h0, ecfg_q}, csr_write_data, csr_write_mask);
                    ecfg_d = wv_s[12:0];
                end
                A_ESTAT: begin
                    wv_s    = merge_f(estat_s, csr_write_data, csr_write_mask);
                    is_sw_d = wv_s[1:0];
                end
                A_ERA:    era_d   = merge_f(era_q, csr_write_data, csr_write_mask);
                A_EENTRY: begin
                    wv_s     = merge_f({eentry_q, 6'h00}, csr_write_data, csr_write_mask);
                    eentry_d = wv_s[31:6];
                end
                A_SAVE0:  save0_d = merge_f(save0_q, csr_write_data, csr_write_mask);
                A_SAVE1:  save1_d = merge_f(save1_q, csr_write_data, csr_write_mask);
                A_SAVE2:  save2_d = merge_f(save2_q, csr_write_data, csr_write_mask);
                A_SAVE3:  save3_d = merge_f(save3_q, csr_write_data, csr_write_mask);
                A_TID:    tid_d   = merge_f(tid_q, csr_write_data, csr_write_mask);
                A_TCFG: begin
                    wv_s       = merge_f(tcfg_ext_s, csr_write_data, csr_write_mask);
                    tcfg_new_s = wv_s[TIMER_W-1:0];
                    tcfg_wr_s  = 1'b1;
                end
                A_TICLR: begin
                    wv_s    = csr_write_data & csr_write_mask;
                    ticlr_s = wv_s[0];
                end
                A_LLBCTL: begin
                    wv_s    = merge_f({29'h0, klo_q, 2'b00}, csr_write_data, csr_write_mask);
                    klo_d   = wv_s[2];
                    wcllb_s = wv_s[1];
                end
                default: wv_s = 32'h0;
            endcase
        end else begin
            wv_s = 32'h0;
        end

        // Timer: a fire both sets IS[11] and either reloads or disarms.
        fire_s = tcfg_q[0] && (tval_q == {TIMER_W{1'b0}});
        if (tcfg_wr_s && tcfg_new_s[0]) begin
            tval_d = {tcfg_new_s[TIMER_W-1:2], 2'b00};
        end else if (tcfg_q[0] && !fire_s) begin
            tval_d = tval_q - {{(TIMER_W-1){1'b0}}, 1'b1};
        end else if (fire_s && tcfg_q[1]) begin
            tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
        end else begin
            tval_d = tval_q;
        end

        if (tcfg_wr_s) begin
            tcfg_d = tcfg_new_s;
        end else if (fire_s && !tcfg_q[1]) begin
            tcfg_d[0] = 1'b0;
        end else begin
            tcfg_d = tcfg_q;
        end

        if (fire_s) begin
            is_timer_d = 1'b1;
        end else if (ticlr_s) begin
            is_timer_d = 1'b0;
        end else begin
            is_timer_d = is_timer_q;
        end

        if (ertn_clr_s || wcllb_s || sc_commit) begin
            llbit_d = 1'b0;
        end else begin
            llbit_d = llbit_q;
        end
        if (llbit_set) begin
            llbit_d = 1'b1;
        end else begin
            llbit_d = llbit_d;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crmd_q     <= 9'h008;
            prmd_q     <= 3'h0;
            ecfg_q     <= 13'h0;
            is_sw_q    <= 2'h0;
            is_hw_q    <= 8'h0;
            is_timer_q <= 1'b0;
            ecode_q    <= 6'h0;
            esubcode_q <= 9'h0;
            era_q      <= 32'h0;
            eentry_q   <= 26'h0;
            save0_q    <= 32'h0;
            save1_q    <= 32'h0;
            save2_q    <= 32'h0;
            save3_q    <= 32'h0;
            tid_q      <= TID_INIT;
            tcfg_q     <= {TIMER_W{1'b0}};
            tval_q     <= {TIMER_W{1'b0}};
            klo_q      <= 1'b0;
            llbit_q    <= 1'b0;
        end else begin
            crmd_q     <= crmd_d;
            prmd_q     <= prmd_d;
            ecfg_q     <= ecfg_d;
            is_sw_q    <= is_sw_d;
            is_hw_q    <= hwi;
            is_timer_q <= is_timer_d;
            ecode_q    <= ecode_d;
            esubcode_q <= esubcode_d;
            era_q      <= era_d;
            eentry_q   <= eentry_d;
            save0_q    <= save0_d;
            save1_q    <= save1_d;
            save2_q    <= save2_d;
            save3_q    <= save3_d;
            tid_q      <= tid_d;
            tcfg_q     <= tcfg_d;
            tval_q     <= tval_d;
            klo_q      <= klo_d;
            llbit_q    <= llbit_d;
        end
    end

    assign llbit        = llbit_q;
    assign exc_entry_pc = {eentry_q, 6'h00};
    assign ertn_pc      = era_q;
    assign int_pending  = crmd_q[2] & (|(estat_s[12:0] & ecfg_q));

endmodule

// File: tb/tb_csr_llbit_unit.sv
// Directed self-checking bench for csr_llbit_unit: CSR access, exception/ERTN,
// LLbit rules and the constant timer.
module tb_csr_llbit_unit;

    localparam logic [31:0] TID_V = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_read_en;
    logic [13:0] csr_read_addr;
    logic [31:0] csr_read_data;
    logic        csr_write_en;
    logic [13:0] csr_write_addr;
    logic [31:0] csr_write_data;
    logic [31:0] csr_write_mask;
    logic        llbit_set;
    logic        sc_commit;
    logic        llbit;
    logic        exc_valid;
    logic [5:0]  exc_ecode;
    logic [8:0]  exc_esubcode;
    logic [31:0] exc_pc;
    logic        ertn;
    logic [7:0]  hwi;
    logic [31:0] exc_entry_pc;
    logic [31:0] ertn_pc;
    logic        int_pending;

    int n_tests = 0;
    int n_fail  = 0;

    csr_llbit_unit #(.TID_INIT(TID_V), .TIMER_W(32)) dut (
        .clk(clk), .rst(rst),
        .csr_read_en(csr_read_en), .csr_read_addr(csr_read_addr), .csr_read_data(csr_read_data),
        .csr_write_en(csr_write_en), .csr_write_addr(csr_write_addr),
        .csr_write_data(csr_write_data), .csr_write_mask(csr_write_mask),
        .llbit_set(llbit_set), .sc_commit(sc_commit), .llbit(llbit),
        .exc_valid(exc_valid), .exc_ecode(exc_ecode), .exc_esubcode(exc_esubcode), .exc_pc(exc_pc),
        .ertn(ertn), .hwi(hwi),
        .exc_entry_pc(exc_entry_pc), .ertn_pc(ertn_pc), .int_pending(int_pending)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [13:0] a, input logic [31:0] exp);
        csr_read_en   = 1'b1;
        csr_read_addr = a;
        #1;
        check_eq(tag, csr_read_data, exp);
        csr_read_en   = 1'b0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
        csr_write_en   = 1'b1;
        csr_write_addr = a;
        csr_write_data = d;
        csr_write_mask = m;
        step();
        csr_write_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        csr_read_en = 1'b0; csr_read_addr = 14'h0;
        csr_write_en = 1'b0; csr_write_addr = 14'h0;
        csr_write_data = 32'h0; csr_write_mask = 32'h0;
        llbit_set = 1'b0; sc_commit = 1'b0;
        exc_valid = 1'b0; exc_ecode = 6'h0; exc_esubcode = 9'h0; exc_pc = 32'h0;
        ertn = 1'b0; hwi = 8'h00;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        chk_rd("rst_crmd", 14'h000, 32'h0000_0008);
        chk_rd("rst_tid", 14'h040, TID_V);
        chk_rd("rst_unimpl", 14'h07F, 32'h0);
        check_eq("rst_llbit", {31'h0, llbit}, 32'h0);
        check_eq("rst_intp", {31'h0, int_pending}, 32'h0);

        // CSRXCHG merge with same-cycle read seeing the old value
        wr(14'h030, 32'hFFFF_0000, 32'hFFFF_FFFF);
        csr_write_en = 1'b1; csr_write_addr = 14'h030;
        csr_write_data = 32'h1234_ABCD; csr_write_mask = 32'h0000_FFFF;
        chk_rd("xchg_same_cyc", 14'h030, 32'hFFFF_0000);
        step();
        csr_write_en = 1'b0;
        chk_rd("xchg_result", 14'h030, 32'hFFFF_ABCD);

        // EENTRY low bits are hardwired zero
        wr(14'h00C, 32'h1C00_80FF, 32'hFFFF_FFFF);
        check_eq("eentry_out", exc_entry_pc, 32'h1C00_80C0);
        wr(14'h042, 32'h0000_1234, 32'hFFFF_FFFF);
        chk_rd("tval_ro", 14'h042, 32'h0);

        // Exception beats a same-cycle ERTN and CSR write
        wr(14'h000, 32'h0000_000F, 32'hFFFF_FFFF);
        chk_rd("crmd_plv3_ie", 14'h000, 32'h0000_000F);
        exc_valid = 1'b1; exc_ecode = 6'h0B; exc_esubcode = 9'h001; exc_pc = 32'h1C00_0100;
        ertn = 1'b1;
        csr_write_en = 1'b1; csr_write_addr = 14'h031;
        csr_write_data = 32'hDEAD_BEEF; csr_write_mask = 32'hFFFF_FFFF;
        step();
        exc_valid = 1'b0; ertn = 1'b0; csr_write_en = 1'b0;
        chk_rd("exc_prmd", 14'h001, 32'h0000_0007);
        chk_rd("exc_crmd", 14'h000, 32'h0000_0008);
        chk_rd("exc_era", 14'h006, 32'h1C00_0100);
        check_eq("exc_ertn_pc", ertn_pc, 32'h1C00_0100);
        chk_rd("exc_estat", 14'h005, 32'h004B_0000);
        chk_rd("exc_wr_drop", 14'h031, 32'h0);

        ertn = 1'b1;
        csr_write_en = 1'b1; csr_write_addr = 14'h032;
        csr_write_data = 32'h5555_5555; csr_write_mask = 32'hFFFF_FFFF;
        step();
        ertn = 1'b0; csr_write_en = 1'b0;
        chk_rd("ertn_crmd", 14'h000, 32'h0000_000F);
        chk_rd("ertn_wr_drop", 14'h032, 32'h0);

        // ESTAT: hwi mirror, only IS[1:0] software writable
        hwi = 8'hA5;
        step();
        chk_rd("estat_hwi", 14'h005, 32'h004B_0294);
        wr(14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk_rd("estat_sw", 14'h005, 32'h004B_0297);
        wr(14'h004, 32'h0000_0801, 32'hFFFF_FFFF);
        check_eq("intp_sw", {31'h0, int_pending}, 32'h1);
        wr(14'h005, 32'h0, 32'hFFFF_FFFF);
        hwi = 8'h00;
        step();
        check_eq("intp_clr", {31'h0, int_pending}, 32'h0);

        // LLbit / LLBCTL
        llbit_set = 1'b1; step(); llbit_set = 1'b0;
        check_eq("ll_set", {31'h0, llbit}, 32'h1);
        wr(14'h060, 32'h0000_0004, 32'hFFFF_FFFF);
        chk_rd("llbctl_klo", 14'h060, 32'h0000_0005);
        ertn = 1'b1; step(); ertn = 1'b0;
        check_eq("ertn_klo_keep", {31'h0, llbit}, 32'h1);
        chk_rd("ertn_klo_clr", 14'h060, 32'h0000_0001);
        ertn = 1'b1; step(); ertn = 1'b0;
        check_eq("ertn_ll_clr", {31'h0, llbit}, 32'h0);
        llbit_set = 1'b1; sc_commit = 1'b1; step(); llbit_set = 1'b0; sc_commit = 1'b0;
        check_eq("set_vs_sc", {31'h0, llbit}, 32'h1);
        sc_commit = 1'b1; step(); sc_commit = 1'b0;
        check_eq("sc_clr", {31'h0, llbit}, 32'h0);
        llbit_set = 1'b1;
        wr(14'h060, 32'h0000_0002, 32'hFFFF_FFFF);
        llbit_set = 1'b0;
        check_eq("set_vs_wcllb", {31'h0, llbit}, 32'h1);
        wr(14'h060, 32'h0000_0002, 32'hFFFF_FFFF);
        check_eq("wcllb_clr", {31'h0, llbit}, 32'h0);

        // Periodic timer: InitVal=2 -> counts 8..0, fires, reloads
        wr(14'h041, 32'h0000_000B, 32'hFFFF_FFFF);
        chk_rd("tcfg_rd", 14'h041, 32'h0000_000B);
        chk_rd("tval_load", 14'h042, 32'h8);
        for (int i = 7; i >= 0; i--) begin
            step();
            chk_rd($sformatf("tval_%0d", i), 14'h042, i);
        end
        chk_rd("is11_prefire", 14'h005, 32'h004B_0000);
        step();
        chk_rd("tval_reload", 14'h042, 32'h8);
        chk_rd("is11_fire", 14'h005, 32'h004B_0800);
        check_eq("intp_timer", {31'h0, int_pending}, 32'h1);
        wr(14'h044, 32'h0000_0001, 32'hFFFF_FFFF);
        chk_rd("ticlr", 14'h005, 32'h004B_0000);
        chk_rd("ticlr_rd0", 14'h044, 32'h0);
        check_eq("intp_ticlr", {31'h0, int_pending}, 32'h0);
        wr(14'h041, 32'h0, 32'hFFFF_FFFF);

        // One-shot timer: InitVal=1 -> 4..0, fire once, En clears
        wr(14'h041, 32'h0000_0005, 32'hFFFF_FFFF);
        chk_rd("os_load", 14'h042, 32'h4);
        repeat (4) step();
        chk_rd("os_zero", 14'h042, 32'h0);
        chk_rd("os_prefire", 14'h005, 32'h004B_0000);
        step();
        chk_rd("os_fire", 14'h005, 32'h004B_0800);
        chk_rd("os_en_clr", 14'h041, 32'h0000_0004);
        wr(14'h044, 32'h0000_0001, 32'hFFFF_FFFF);
        repeat (12) step();
        chk_rd("os_no_refire", 14'h005, 32'h004B_0000);
        chk_rd("os_tval_hold", 14'h042, 32'h0);

        // Mid-operation reset
        wr(14'h041, 32'h0000_0043, 32'hFFFF_FFFF);
        step();
        rst = 1'b1;
        #1;
        chk_rd("mrst_tval", 14'h042, 32'h0);
        chk_rd("mrst_crmd", 14'h000, 32'h0000_0008);
        chk_rd("mrst_save0", 14'h030, 32'h0);
        step();
        rst = 1'b0;
        step();
        chk_rd("mrst_tval_hold", 14'h042, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
